// File: rtl/wb_int_arb_pkg.sv
// Shared definitions for the integer writeback arbiter:
// bus widths, exception flag bit positions and encoded exception types.
package wb_int_arb_pkg;

    localparam int RS_INT_ADDR_W = 3;
    localparam int WB_DATA_W     = 32;
    localparam int EXC_FLAG_W    = 8;

    localparam int EXC_BIT_RI   = 0;
    localparam int EXC_BIT_OV   = 1;
    localparam int EXC_BIT_BP   = 2;
    localparam int EXC_BIT_SYS  = 3;
    localparam int EXC_BIT_ERET = 4;

    typedef enum logic [7:0] {
        EXC_TYPE_NULL = 8'h00,
        EXC_TYPE_RI   = 8'h01,
        EXC_TYPE_OV   = 8'h02,
        EXC_TYPE_BP   = 8'h03,
        EXC_TYPE_SYS  = 8'h04,
        EXC_TYPE_ERET = 8'h05
    } exc_type_e;

    // Fixed priority RI > OV > BP > SYS > ERET.
    function automatic exc_type_e exc_encode(
        input logic [EXC_FLAG_W-1:0] flags
    );
        exc_type_e code;
        code = EXC_TYPE_NULL;
        if (flags[EXC_BIT_RI])        code = EXC_TYPE_RI;
        else if (flags[EXC_BIT_OV])   code = EXC_TYPE_OV;
        else if (flags[EXC_BIT_BP])   code = EXC_TYPE_BP;
        else if (flags[EXC_BIT_SYS])  code = EXC_TYPE_SYS;
        else if (flags[EXC_BIT_ERET]) code = EXC_TYPE_ERET;
        return code;
    endfunction

endpackage

// File: rtl/wb_int_arb_chan_fifo.sv
// Per-channel result buffer: small FIFO with registered count,
// flushable, storage left unreset.
module wb_chan_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             ready,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next pointers/count; pointers wrap naturally at power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage, written on accepted push only.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign ready = (cnt_q != CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/wb_int_arb.sv
// Integer writeback arbiter: per-channel buffers, round-robin grant,
// registered commit port toward RS Int.
module wb_int_arb
    import wb_int_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = RS_INT_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int EXC_W  = EXC_FLAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*ADDR_W-1:0] in_rs_addr,
    input  logic [NUM_CH*EXC_W-1:0]  in_exc_flags,
    input  logic [NUM_CH*DATA_W-1:0] in_result,
    output logic                     commit_en,
    output logic [ADDR_W-1:0]        commit_addr,
    output logic [EXC_W-1:0]         commit_exc_type,
    output logic [DATA_W-1:0]        commit_data
);

    localparam int ENT_W = ADDR_W + EXC_W + DATA_W;
    localparam int LG_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] empty;
    logic [ENT_W-1:0]  wdata [NUM_CH];
    logic [ENT_W-1:0]  rdata [NUM_CH];

    logic              gnt_vld;
    logic [LG_W-1:0]   gnt_idx;
    logic [LG_W-1:0]   last_grant_q, last_grant_d;

    logic              commit_en_q, commit_en_d;
    logic [ADDR_W-1:0] commit_addr_q, commit_addr_d;
    logic [EXC_W-1:0]  commit_exc_q, commit_exc_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [EXC_W-1:0] flags;
        exc_type_e        code;

        assign flags = in_exc_flags[gi*EXC_W +: EXC_W];
        assign code  = exc_encode(EXC_FLAG_W'(flags));
        assign push[gi] = in_valid[gi] && in_ready[gi] && !flush;
        assign pop[gi]  = gnt_vld && (gnt_idx == LG_W'(gi));
        assign wdata[gi] = {in_rs_addr[gi*ADDR_W +: ADDR_W],
                            EXC_W'(code),
                            in_result[gi*DATA_W +: DATA_W]};

        wb_chan_fifo #(
            .DEPTH(DEPTH),
            .WIDTH(ENT_W)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .flush(flush),
            .push (push[gi]),
            .wdata(wdata[gi]),
            .pop  (pop[gi]),
            .rdata(rdata[gi]),
            .ready(in_ready[gi]),
            .empty(empty[gi])
        );
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_CH;
            if (!gnt_vld && !empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = LG_W'(cand);
            end
        end
        if (flush) gnt_vld = 1'b0;
    end

    // Commit register load; fields hold when nothing is granted.
    always_comb begin
        commit_en_d   = gnt_vld;
        commit_addr_d = commit_addr_q;
        commit_exc_d  = commit_exc_q;
        commit_data_d = commit_data_q;
        last_grant_d  = last_grant_q;
        if (gnt_vld) begin
            {commit_addr_d, commit_exc_d, commit_data_d} = rdata[gnt_idx];
            last_grant_d = gnt_idx;
        end
    end

    // Commit and arbiter state; reset makes channel 0 win first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_en_q   <= 1'b0;
            commit_addr_q <= '0;
            commit_exc_q  <= '0;
            commit_data_q <= '0;
            last_grant_q  <= LG_W'(NUM_CH - 1);
        end else begin
            commit_en_q   <= commit_en_d;
            commit_addr_q <= commit_addr_d;
            commit_exc_q  <= commit_exc_d;
            commit_data_q <= commit_data_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign commit_en       = commit_en_q;
    assign commit_addr     = commit_addr_q;
    assign commit_exc_type = commit_exc_q;
    assign commit_data     = commit_data_q;

endmodule

// File: tb/tb_wb_int_arb.sv
// Bench for wb_int_arb: cycle model with per-channel queues and a
// commit scoreboard, plus directed checks at key points.
module tb_wb_int_arb;
    import wb_int_arb_pkg::*;

    localparam int NCH = 2;
    localparam int DEP = 2;
    localparam int AW  = 3;
    localparam int DW  = 32;
    localparam int EW  = 8;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*AW-1:0] in_rs_addr;
    logic [NCH*EW-1:0] in_exc_flags;
    logic [NCH*DW-1:0] in_result;
    logic              commit_en;
    logic [AW-1:0]     commit_addr;
    logic [EW-1:0]     commit_exc_type;
    logic [DW-1:0]     commit_data;

    wb_int_arb #(
        .NUM_CH(NCH), .DEPTH(DEP), .ADDR_W(AW),
        .DATA_W(DW), .EXC_W(EW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs_addr     (in_rs_addr),
        .in_exc_flags   (in_exc_flags),
        .in_result      (in_result),
        .commit_en      (commit_en),
        .commit_addr    (commit_addr),
        .commit_exc_type(commit_exc_type),
        .commit_data    (commit_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [EW-1:0] exc;
        logic [DW-1:0] data;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    ent_t mq [NCH][$];
    ent_t sb [$];
    int   m_last = NCH - 1;
    logic m_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] enc(input logic [EW-1:0] f);
        if (f[EXC_BIT_RI])   return EW'(EXC_TYPE_RI);
        if (f[EXC_BIT_OV])   return EW'(EXC_TYPE_OV);
        if (f[EXC_BIT_BP])   return EW'(EXC_TYPE_BP);
        if (f[EXC_BIT_SYS])  return EW'(EXC_TYPE_SYS);
        if (f[EXC_BIT_ERET]) return EW'(EXC_TYPE_ERET);
        return EW'(EXC_TYPE_NULL);
    endfunction

    // Reference model: grant from pre-edge state, then accept pushes.
    always @(posedge clk) begin
        int   g;
        bit   ok [NCH];
        ent_t e;
        if (!rst) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_last = NCH - 1;
            m_en   = 1'b0;
        end else if (flush) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_en = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++)
                ok[c] = in_valid[c] && (mq[c].size() < DEP);
            g = -1;
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (m_last + k) % NCH;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            m_en = (g >= 0);
            if (g >= 0) begin
                sb.push_back(mq[g].pop_front());
                m_last = g;
            end
            for (int c = 0; c < NCH; c++) begin
                if (ok[c]) begin
                    e.addr = in_rs_addr[c*AW +: AW];
                    e.exc  = enc(in_exc_flags[c*EW +: EW]);
                    e.data = in_result[c*DW +: DW];
                    mq[c].push_back(e);
                end
            end
        end
    end

    // Compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        ent_t e;
        if (mon_on) begin
            chk("commit_en", 64'(commit_en), 64'(m_en));
            for (int c = 0; c < NCH; c++)
                chk($sformatf("in_ready%0d", c), 64'(in_ready[c]),
                    64'(mq[c].size() < DEP));
            if (m_en && sb.size() > 0) begin
                e = sb.pop_front();
                chk("commit_addr", 64'(commit_addr), 64'(e.addr));
                chk("commit_exc", 64'(commit_exc_type), 64'(e.exc));
                chk("commit_data", 64'(commit_data), 64'(e.data));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = '0;
        flush    = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [AW-1:0] a,
                          input logic [EW-1:0] f,
                          input logic [DW-1:0] d);
        in_valid[ch] = 1'b1;
        in_rs_addr[ch*AW +: AW]   = a;
        in_exc_flags[ch*EW +: EW] = f;
        in_result[ch*DW +: DW]    = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    logic [EW-1:0] fl;

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        in_valid = '0;
        in_rs_addr = '0;
        in_exc_flags = '0;
        in_result = '0;
        cyc();
        cyc();
        chk("rst_en", 64'(commit_en), 64'(0));
        chk("rst_addr", 64'(commit_addr), 64'(0));
        chk("rst_exc", 64'(commit_exc_type), 64'(0));
        chk("rst_data", 64'(commit_data), 64'(0));
        rst = 1'b1;
        mon_on = 1'b1;
        cyc();
        chk("rst_ready", 64'(in_ready), 64'(2'b11));

        // Single push, two-cycle latency, fields hold afterwards.
        set_ch(0, 3'd5, 8'h00, 32'h1234);
        cyc();
        idle();
        chk("lat_en0", 64'(commit_en), 64'(0));
        cyc();
        chk("lat_en1", 64'(commit_en), 64'(1));
        chk("lat_addr", 64'(commit_addr), 64'(5));
        chk("lat_data", 64'(commit_data), 64'(32'h1234));
        chk("lat_exc", 64'(commit_exc_type), 64'(EXC_TYPE_NULL));
        cyc();
        chk("hold_en", 64'(commit_en), 64'(0));
        chk("hold_addr", 64'(commit_addr), 64'(5));

        // Simultaneous pushes after reset: ch0 first.
        do_reset();
        set_ch(0, 3'd1, 8'h00, 32'hA1);
        set_ch(1, 3'd2, 8'h00, 32'hB2);
        cyc();
        idle();
        cyc();
        chk("rr_first", 64'(commit_addr), 64'(1));
        cyc();
        chk("rr_second", 64'(commit_addr), 64'(2));
        chk("rr_en", 64'(commit_en), 64'(1));

        // Exception priority.
        fl = '0;
        fl[EXC_BIT_OV] = 1'b1;
        fl[EXC_BIT_SYS] = 1'b1;
        set_ch(1, 3'd3, fl, 32'hC3);
        cyc();
        fl = '0;
        fl[EXC_BIT_RI] = 1'b1;
        fl[EXC_BIT_ERET] = 1'b1;
        set_ch(1, 3'd4, fl, 32'hD4);
        cyc();
        idle();
        chk("exc_ov", 64'(commit_exc_type), 64'(EXC_TYPE_OV));
        cyc();
        chk("exc_ri", 64'(commit_exc_type), 64'(EXC_TYPE_RI));
        repeat (3) cyc();

        // Backpressure: both channels push every cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_ch(0, AW'(i), 8'h00, 32'h100 + i);
            set_ch(1, AW'(i + 4), 8'h00, 32'h200 + i);
            cyc();
            if (i == 2) chk("full_ready0", 64'(in_ready[0]), 64'(0));
        end
        idle();
        repeat (8) cyc();
        chk("bp_drained", 64'(sb.size()), 64'(0));

        // Flush with buffered entries.
        for (int i = 0; i < 3; i++) begin
            set_ch(0, 3'd6, 8'h00, 32'h300 + i);
            set_ch(1, 3'd7, 8'h00, 32'h400 + i);
            cyc();
        end
        flush = 1'b1;
        cyc();
        idle();
        chk("flush_en", 64'(commit_en), 64'(0));
        chk("flush_ready", 64'(in_ready), 64'(2'b11));
        repeat (4) cyc();

        // Reset while entries are buffered.
        for (int i = 0; i < 3; i++) begin
            set_ch(0, 3'd2, 8'h00, 32'h500 + i);
            set_ch(1, 3'd3, 8'h00, 32'h600 + i);
            cyc();
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        idle();
        chk("mrst_en", 64'(commit_en), 64'(0));
        chk("mrst_addr", 64'(commit_addr), 64'(0));
        chk("mrst_data", 64'(commit_data), 64'(0));
        chk("mrst_exc", 64'(commit_exc_type), 64'(0));
        cyc();
        chk("mrst_ready", 64'(in_ready), 64'(2'b11));
        repeat (4) cyc();

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            idle();
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 3) != 0)
                    set_ch(c, AW'($urandom), EW'($urandom),
                           $urandom);
            flush = ($urandom_range(0, 19) == 0);
            cyc();
        end
        idle();
        repeat (8) cyc();
        chk("final_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_int_arb.md
WB_INT_ARB -- requirements
Module: wb_int_arb

Interface
REQ-001 Parameter NUM_CH, default 2: number of integer execution channels feeding writeback (1..8).
REQ-002 Parameter DEPTH, default 2: entries per channel buffer (power of two, 2..8).
REQ-003 Parameter ADDR_W, default 3: RS Int address width.
REQ-004 Parameter DATA_W, default 32: result width.
REQ-005 Parameter EXC_W, default 8: exception flag/type width, per the shared exception header.
REQ-006 clk  input  1  clock; rising-edge only.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 flush  input  1  pipeline flush; discards all buffered and pending results.
REQ-009 in_valid  input  NUM_CH  per-channel result valid.
REQ-010 in_ready  output  NUM_CH  per-channel buffer not full.
REQ-011 in_rs_addr  input  NUM_CH*ADDR_W  per-channel RS Int slot, channel i at bits [i*ADDR_W +: ADDR_W].
REQ-012 in_exc_flags  input  NUM_CH*EXC_W  per-channel raw exception flag vector, packed likewise.
REQ-013 in_result  input  NUM_CH*DATA_W  per-channel result data, packed likewise.
REQ-014 commit_en  output  1  commit valid to RS Int.
REQ-015 commit_addr  output  ADDR_W  committed RS Int slot.
REQ-016 commit_exc_type  output  EXC_W  encoded exception type.
REQ-017 commit_data  output  DATA_W  committed result.

Function
REQ-018 Push on channel i SHALL occur iff in_valid[i] && in_ready[i] && !flush; in_ready[i] = (count_i != DEPTH), driven from registered count only.
REQ-019 Exception encoding SHALL occur before buffering, fixed priority RI > OV > BP > SYS > ERET; no flag set -> EXC_TYPE_NULL.
REQ-020 Each channel buffer SHALL be FIFO; pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-021 Arbiter SHALL grant one non-empty channel per cycle, round-robin: search starts at last_grant+1 modulo NUM_CH; last_grant updates only on a grant.
REQ-022 Granted entry SHALL pop the same cycle and appear on commit_* the next cycle with commit_en=1; no grant -> commit_en=0, other commit_* hold last values.
REQ-023 Latency: push at edge t on an idle block -> commit_en high in the cycle following edge t+1; throughput one commit per cycle total.
REQ-024 Simultaneous push and pop on one channel SHALL leave count unchanged; allowed at any non-full count.
REQ-025 Empty-buffer push SHALL NOT bypass to commit the same cycle.
REQ-026 flush high at edge t SHALL zero all counts and pointers, drop same-cycle pushes, force commit_en=0 after edge t; last_grant preserved.
REQ-027 NUM_CH=1 SHALL degenerate to a plain FIFO with registered commit.

Reset
REQ-028 With rst low at a rising edge, SHALL clear commit_en, commit_addr, commit_exc_type, commit_data, all counts, pointers; last_grant = NUM_CH-1, so channel 0 wins first.
REQ-029 Reset mid-operation SHALL discard all buffered entries; in_ready all-ones the cycle after release.
REQ-030 Buffer storage arrays need no reset.

Structure
REQ-031 Exception bit positions and EXC_TYPE_* codes SHALL come from the shared exception header; RS Int address and data bus widths from the shared bus header as parameter defaults.
REQ-032 Per-channel buffer SHALL be one sub-module, wb_chan_fifo (parameters DEPTH, WIDTH), instantiated NUM_CH times via generate.
REQ-033 Arbiter and commit register SHALL live in wb_int_arb.

Verification
REQ-034 Single push ch0 addr=5, data=0x1234, no flags -> commit_en one cycle, commit_addr=5, data=0x1234, exc=NULL, two cycles after push.
REQ-035 ch0 and ch1 push same cycle (addr 1, 2) after reset -> commits addr 1 then addr 2 on consecutive cycles.
REQ-036 Flags OV|SYS on ch1 -> commit_exc_type=EXC_TYPE_OV; RI|ERET -> EXC_TYPE_RI.
REQ-037 DEPTH=2, ch0 pushes three cycles while ch1 keeps arbiter busy -> in_ready[0] low when full; no entry lost; order per channel preserved.
REQ-038 Fill both channels, assert flush one cycle -> commit_en 0 next cycle, in_ready all-ones, no stale commits afterward.
REQ-039 rst low for one edge while both buffers hold entries -> all outputs zero, no later commit of pre-reset data.
